// File: rtl/knight_pkg.sv
// knight_pkg: shared command encodings and FSM state type for the knight tour
// sequencer and its move decoder.
package knight_pkg;

  // Headings understood by the command processor
  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  // Opcodes
  localparam logic [3:0] MOVE         = 4'h4;
  localparam logic [3:0] MOVE_FANFARE = 4'h5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  // Command word layout: {opcode, heading, squares}
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] heading,
                                         input logic [3:0] squares);
    return {op, heading, squares};
  endfunction

endpackage

// File: rtl/tour_move_lut.sv
// tour_move_lut: combinational decode of a one-hot knight move into the
// vertical leg command and the horizontal (fanfare) leg command.
//   move     : one-hot move word; lowest set bit wins if several are set
//   vert_cmd : {MOVE, NORTH/SOUTH, |dy|}
//   horz_cmd : {MOVE_FANFARE, EAST/WEST, |dx|}
// An all-zero move decodes to zero commands.
module tour_move_lut
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  always_comb begin
    vert_cmd = '0;
    horz_cmd = '0;
    // Ordered casez: the first matching item is the lowest set bit
    casez (move)
      8'b???????1: begin  // (+1,+2)
        vert_cmd = mk_cmd(MOVE, NORTH, 4'd2);
        horz_cmd = mk_cmd(MOVE_FANFARE, EAST, 4'd1);
      end
      8'b??????10: begin  // (-1,+2)
        vert_cmd = mk_cmd(MOVE, NORTH, 4'd2);
        horz_cmd = mk_cmd(MOVE_FANFARE, WEST, 4'd1);
      end
      8'b?????100: begin  // (-2,+1)
        vert_cmd = mk_cmd(MOVE, NORTH, 4'd1);
        horz_cmd = mk_cmd(MOVE_FANFARE, WEST, 4'd2);
      end
      8'b????1000: begin  // (-2,-1)
        vert_cmd = mk_cmd(MOVE, SOUTH, 4'd1);
        horz_cmd = mk_cmd(MOVE_FANFARE, WEST, 4'd2);
      end
      8'b???10000: begin  // (-1,-2)
        vert_cmd = mk_cmd(MOVE, SOUTH, 4'd2);
        horz_cmd = mk_cmd(MOVE_FANFARE, WEST, 4'd1);
      end
      8'b??100000: begin  // (+1,-2)
        vert_cmd = mk_cmd(MOVE, SOUTH, 4'd2);
        horz_cmd = mk_cmd(MOVE_FANFARE, EAST, 4'd1);
      end
      8'b?1000000: begin  // (+2,-1)
        vert_cmd = mk_cmd(MOVE, SOUTH, 4'd1);
        horz_cmd = mk_cmd(MOVE_FANFARE, EAST, 4'd2);
      end
      8'b10000000: begin  // (+2,+1)
        vert_cmd = mk_cmd(MOVE, NORTH, 4'd1);
        horz_cmd = mk_cmd(MOVE_FANFARE, EAST, 4'd2);
      end
      default: begin
        vert_cmd = '0;
        horz_cmd = '0;
      end
    endcase
  end

endmodule

// File: rtl/tour_sequencer.sv
// tour_sequencer: walks the solved knight tour in move memory and issues each
// move as a vertical leg then a horizontal fanfare leg to the command
// processor, taking over the command/response path while busy.
//   clk, rst      : clock, synchronous active-high reset
//   start_tour    : pulse, move list valid (honoured only in IDLE)
//   move          : one-hot move read from memory at mv_indx
//   clr_cmd_rdy   : command processor accepted cmd
//   send_resp     : command processor finished the current command
//   mv_indx       : move memory address
//   usurp         : sequencer owns cmd/cmd_rdy/resp (all states but IDLE)
//   cmd, cmd_rdy  : command word and its valid flag
//   resp          : response byte for the UART
//   tour_done     : pulse after the final move completes
//   tour_err      : pulse when an empty move word is found
module tour_sequencer
  import knight_pkg::*;
#(
  parameter int         TOUR_LEN  = 24,
  parameter logic [7:0] RESP_DONE = 8'hA5,
  parameter logic [7:0] RESP_MOVE = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [4:0]  mv_indx,
  output logic        usurp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_done,
  output logic        tour_err
);

  localparam logic [4:0] LAST_IDX = 5'(TOUR_LEN - 1);

  state_t      state, state_nxt;
  logic [4:0]  mv_indx_nxt;
  logic [15:0] cmd_nxt;
  logic        cmd_rdy_nxt;
  logic        tour_done_nxt;
  logic        tour_err_nxt;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  tour_move_lut u_lut (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last_move = (mv_indx == LAST_IDX);
  assign usurp     = (state != IDLE);
  assign resp      = (state == WAIT_H && last_move) ? RESP_DONE : RESP_MOVE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mv_indx   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      tour_done <= 1'b0;
      tour_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mv_indx   <= mv_indx_nxt;
      cmd       <= cmd_nxt;
      cmd_rdy   <= cmd_rdy_nxt;
      tour_done <= tour_done_nxt;
      tour_err  <= tour_err_nxt;
    end
  end

  // In VERT/HORZ, cmd_rdy low marks the first cycle of the leg: the move word
  // at the new mv_indx is decoded and latched then, so cmd_rdy rises one cycle
  // after entry and cmd stays frozen until the leg is accepted.
  always_comb begin
    state_nxt     = state;
    mv_indx_nxt   = mv_indx;
    cmd_nxt       = cmd;
    cmd_rdy_nxt   = cmd_rdy;
    tour_done_nxt = 1'b0;
    tour_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_tour) begin
          state_nxt   = VERT;
          mv_indx_nxt = '0;
        end
      end
      VERT: begin
        if (!cmd_rdy) begin
          if (move == '0) begin
            state_nxt    = IDLE;
            tour_err_nxt = 1'b1;
          end else begin
            cmd_nxt     = vert_cmd;
            cmd_rdy_nxt = 1'b1;
          end
        end else if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          state_nxt   = WAIT_V;
        end
      end
      WAIT_V: begin
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        if (!cmd_rdy) begin
          cmd_nxt     = horz_cmd;
          cmd_rdy_nxt = 1'b1;
        end else if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          state_nxt   = WAIT_H;
        end
      end
      WAIT_H: begin
        if (send_resp) begin
          if (last_move) begin
            state_nxt     = IDLE;
            tour_done_nxt = 1'b1;
          end else begin
            state_nxt   = VERT;
            mv_indx_nxt = mv_indx + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_sequencer.sv
module tb_tour_sequencer;

  localparam int TOUR_LEN = 24;

  logic        clk = 1'b0;
  logic        rst, start_tour, clr_cmd_rdy, send_resp;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic        usurp, cmd_rdy, tour_done, tour_err;
  logic [15:0] cmd;
  logic [7:0]  resp;

  logic [7:0]  mem [0:31];
  int          vectors = 0;
  int          miscompares = 0;

  // Hand-derived decode table for single-bit moves b0..b7
  logic [15:0] ev_tbl [8] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                              16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
  logic [15:0] eh_tbl [8] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
                              16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};

  assign move = mem[mv_indx];

  always #5 clk = ~clk;

  tour_sequencer #(
    .TOUR_LEN  (TOUR_LEN),
    .RESP_DONE (8'hA5),
    .RESP_MOVE (8'h5A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_tour  (start_tour),
    .move        (move),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .mv_indx     (mv_indx),
    .usurp       (usurp),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .resp        (resp),
    .tour_done   (tour_done),
    .tour_err    (tour_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(tag, cmd_rdy, 1'b1);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++)
      mem[i] = (8'h01 << (i % 8)) | ((i >= 8 && (i % 8) != 7) ? 8'h80 : 8'h00);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  // Entered with the DUT freshly in VERT (cmd_rdy still low); returns just
  // after the send_resp edge that ends WAIT_H.
  task automatic do_move(input int idx, input logic [15:0] ev, input logic [15:0] eh,
                         input bit last, input bit poke, input bit rst_wh);
    chk("usurp_vert", usurp, 1'b1);
    wait_rdy("rdy_vert");
    chk("cmd_vert", cmd, ev);
    chk("mv_indx", mv_indx, 16'(idx));
    step();
    chk("cmd_vert_hold", cmd, ev);
    chk("rdy_vert_hold", cmd_rdy, 1'b1);
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    chk("rdy_wait_v", cmd_rdy, 1'b0);
    chk("usurp_wait_v", usurp, 1'b1);
    chk("resp_wait_v", resp, 8'h5A);
    if (poke) start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    step();
    chk("rdy_wait_v_hold", cmd_rdy, 1'b0);
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    chk("usurp_horz", usurp, 1'b1);
    wait_rdy("rdy_horz");
    chk("cmd_horz", cmd, eh);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    chk("rdy_wait_h", cmd_rdy, 1'b0);
    chk("usurp_wait_h", usurp, 1'b1);
    chk("resp_wait_h", resp, last ? 8'hA5 : 8'h5A);
    if (rst_wh) begin
      pulse_rst();
      chk("rst_cmd", cmd, 16'h0000);
      chk("rst_rdy", cmd_rdy, 1'b0);
      chk("rst_usurp", usurp, 1'b0);
      chk("rst_done", tour_done, 1'b0);
      chk("rst_err", tour_err, 1'b0);
      chk("rst_indx", mv_indx, 16'h0000);
      return;
    end
    step();
    chk("rdy_wait_h_hold", cmd_rdy, 1'b0);
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    chk("tour_done", tour_done, last);
    chk("usurp_after", usurp, !last);
    if (last) begin
      step();
      chk("tour_done_pulse", tour_done, 1'b0);
      chk("usurp_idle", usurp, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_tour = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;
    step();
    step();
    rst = 1'b0;
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_rdy", cmd_rdy, 1'b0);
    chk("reset_usurp", usurp, 1'b0);
    chk("reset_done", tour_done, 1'b0);
    chk("reset_err", tour_err, 1'b0);
    chk("reset_indx", mv_indx, 16'h0000);

    // b0 move: vertical then horizontal leg
    mem[0] = 8'h01;
    start();
    chk("start_usurp", usurp, 1'b1);
    chk("start_indx", mv_indx, 16'h0000);
    chk("start_rdy_latency", cmd_rdy, 1'b0);
    do_move(0, 16'h4002, 16'h5BF1, 1'b0, 1'b0, 1'b0);
    chk("next_indx", mv_indx, 16'h0001);
    pulse_rst();

    // b3 move
    mem[0] = 8'h08;
    start();
    do_move(0, 16'h47F1, 16'h53F2, 1'b0, 1'b0, 1'b0);
    pulse_rst();

    // Two bits set (b1 wins) and start_tour while busy
    mem[0] = 8'h06;
    start();
    do_move(0, 16'h4002, 16'h53F1, 1'b0, 1'b1, 1'b0);
    chk("busy_start_indx", mv_indx, 16'h0001);
    pulse_rst();

    // Full tour
    fill_pattern();
    start();
    for (int i = 0; i < TOUR_LEN; i++)
      do_move(i, ev_tbl[i % 8], eh_tbl[i % 8], i == TOUR_LEN - 1, 1'b0, 1'b0);
    step();
    chk("idle_no_done", tour_done, 1'b0);
    chk("idle_resp", resp, 8'h5A);

    // Empty move word at index 3
    fill_pattern();
    mem[3] = 8'h00;
    start();
    for (int i = 0; i < 3; i++)
      do_move(i, ev_tbl[i % 8], eh_tbl[i % 8], 1'b0, 1'b0, 1'b0);
    chk("err_entry_indx", mv_indx, 16'h0003);
    step();
    chk("tour_err", tour_err, 1'b1);
    chk("err_rdy", cmd_rdy, 1'b0);
    chk("err_usurp", usurp, 1'b0);
    step();
    chk("tour_err_pulse", tour_err, 1'b0);
    chk("err_rdy_idle", cmd_rdy, 1'b0);
    chk("err_done", tour_done, 1'b0);

    // Reset in WAIT_H at index 10, then restart
    fill_pattern();
    start();
    for (int i = 0; i < 10; i++)
      do_move(i, ev_tbl[i % 8], eh_tbl[i % 8], 1'b0, 1'b0, 1'b0);
    do_move(10, ev_tbl[2], eh_tbl[2], 1'b0, 1'b0, 1'b1);
    step();
    chk("post_rst_usurp", usurp, 1'b0);
    start();
    chk("restart_indx", mv_indx, 16'h0000);
    chk("restart_usurp", usurp, 1'b1);
    do_move(0, ev_tbl[0], eh_tbl[0], 1'b0, 1'b0, 1'b0);
    pulse_rst();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
